// File: rtl/fm0_pkg.sv
// Shared definitions for the FM0 backscatter encoder: state encoding,
// default preamble pattern and pilot length.
package fm0_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PILOT,
    ST_PREAMBLE,
    ST_DATA,
    ST_DUMMY,
    ST_FINISH
  } fm0_state_t;

  localparam int          DEF_PILOT_LEN = 12;
  localparam logic [11:0] DEF_PREAMBLE  = 12'b110100100011;
  localparam int          PREAMBLE_LEN  = 12;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/half_tick_gen.sv
// Samples the divided clock level and flags each edge as a one-cycle
// half-symbol tick.
module half_tick_gen (
  input  logic clock,
  input  logic reset,
  input  logic clk_div,
  output logic tick
);

  logic clk_div_q;

  // Reset level matches the divider's own reset level so no tick fires on release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) clk_div_q <= 1'b1;
    else        clk_div_q <= clk_div;
  end

  assign tick = clk_div ^ clk_div_q;

endmodule

// File: rtl/fm0_encoder.sv
// FM0 reply-frame encoder: optional pilot tone, preamble, data symbols,
// a trailing dummy data-1 and a return to level 0, paced by half-symbol ticks.
module fm0_encoder
  import fm0_pkg::*;
#(
  parameter int          PILOT_LEN = DEF_PILOT_LEN,
  parameter logic [11:0] PREAMBLE  = DEF_PREAMBLE
) (
  input  logic clock,
  input  logic reset,
  input  logic clk_div,
  input  logic start,
  input  logic trext,
  input  logic in_valid,
  input  logic in_data,
  input  logic in_last,
  output logic in_ready,
  output logic bs_out,
  output logic busy,
  output logic done,
  output logic underrun
);

  localparam int HALF_MAX = 2 * max2(PILOT_LEN, PREAMBLE_LEN);
  localparam int CNT_W    = $clog2(HALF_MAX);
  localparam logic [CNT_W-1:0] PILOT_END = CNT_W'(2 * PILOT_LEN - 1);
  localparam logic [CNT_W-1:0] PRE_END   = CNT_W'(PREAMBLE_LEN - 1);

  fm0_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             bit_q;
  logic             last_q;
  logic [3:0]       pre_idx;

  half_tick_gen u_tick (
    .clock   (clock),
    .reset   (reset),
    .clk_div (clk_div),
    .tick    (tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // In DATA and DUMMY, cnt[0] is the half-symbol phase: 0 = boundary, 1 = mid.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (start) state_nxt = trext ? ST_PILOT : ST_PREAMBLE;
      ST_PILOT:    if (tick && cnt == PILOT_END) state_nxt = ST_PREAMBLE;
      ST_PREAMBLE: if (tick && cnt == PRE_END) state_nxt = ST_DATA;
      ST_DATA: begin
        if (tick) begin
          if (!cnt[0]) begin
            if (!in_valid) state_nxt = ST_DUMMY;
          end else if (last_q) begin
            state_nxt = ST_DUMMY;
          end
        end
      end
      ST_DUMMY:    if (tick && cnt[0]) state_nxt = ST_FINISH;
      ST_FINISH:   if (tick) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = tick && (state == ST_DATA) && !cnt[0];
    busy     = (state != ST_IDLE);
  end

  assign pre_idx = 4'(PREAMBLE_LEN - 1) - cnt[3:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      bs_out   <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
      bit_q    <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (start) begin
          underrun <= 1'b0;
          cnt      <= '0;
        end
      end else if (tick) begin
        if (state_nxt != state)
          cnt <= '0;
        else if (state == ST_DATA || state == ST_DUMMY)
          cnt <= {{(CNT_W-1){1'b0}}, ~cnt[0]};
        else
          cnt <= cnt + 1'b1;

        case (state)
          ST_PILOT:    bs_out <= ~bs_out;
          ST_PREAMBLE: bs_out <= PREAMBLE[pre_idx];
          ST_DATA: begin
            if (!cnt[0]) begin
              if (in_valid) begin
                bs_out <= ~bs_out;
                bit_q  <= in_data;
                last_q <= in_last;
              end else begin
                underrun <= 1'b1;
              end
            end else if (!bit_q) begin
              bs_out <= ~bs_out;
            end
          end
          ST_DUMMY:    if (!cnt[0]) bs_out <= ~bs_out;
          ST_FINISH: begin
            bs_out <= 1'b0;
            done   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fm0_encoder.sv
// Self-checking bench for fm0_encoder: per-tick expected bs_out levels and
// in_ready strobes are generated from the FM0 frame rules.
module tb_fm0_encoder;

  localparam int PILOT_LEN = 12;

  logic clock = 1'b0;
  logic reset, clk_div, start, trext, in_valid, in_data, in_last;
  logic in_ready, bs_out, busy, done, underrun;

  int n_tests = 0;
  int n_fail  = 0;

  bit   bits[$];
  logic exp_lvl[$];
  logic exp_rdy[$];

  always #5 clock = ~clock;

  fm0_encoder #(.PILOT_LEN(PILOT_LEN)) dut (
    .clock    (clock),
    .reset    (reset),
    .clk_div  (clk_div),
    .start    (start),
    .trext    (trext),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .bs_out   (bs_out),
    .busy     (busy),
    .done     (done),
    .underrun (underrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected level after every tick of a frame, plus which ticks are data boundaries.
  task automatic build(input bit tr, input int nbits, input int ur);
    logic        lvl;
    logic [11:0] pre;
    int          nd;
    pre = 12'b110100100011;
    exp_lvl.delete();
    exp_rdy.delete();
    lvl = 1'b0;
    if (tr) for (int i = 0; i < 2 * PILOT_LEN; i++) begin
      lvl = ~lvl; exp_lvl.push_back(lvl); exp_rdy.push_back(1'b0);
    end
    for (int i = 0; i < 12; i++) begin
      lvl = pre[11 - i]; exp_lvl.push_back(lvl); exp_rdy.push_back(1'b0);
    end
    nd = (ur >= 0) ? ur : nbits;
    for (int i = 0; i < nd; i++) begin
      lvl = ~lvl; exp_lvl.push_back(lvl); exp_rdy.push_back(1'b1);
      if (!bits[i]) lvl = ~lvl;
      exp_lvl.push_back(lvl); exp_rdy.push_back(1'b0);
    end
    if (ur >= 0) begin
      exp_lvl.push_back(lvl); exp_rdy.push_back(1'b1);
    end
    lvl = ~lvl; exp_lvl.push_back(lvl); exp_rdy.push_back(1'b0);
    exp_lvl.push_back(lvl); exp_rdy.push_back(1'b0);
    exp_lvl.push_back(1'b0); exp_rdy.push_back(1'b0);
  endtask

  task automatic fill_random(input int n);
    bits.delete();
    for (int i = 0; i < n; i++) bits.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic run_frame(input bit tr, input int nbits, input int ur,
                           input int stall_at, input int restart_at, input int abort_at);
    int   dp, hs, last_t;
    bit   aborted;
    logic held;
    build(tr, nbits, ur);
    last_t = exp_lvl.size() - 1;
    @(negedge clock);
    start = 1'b1; trext = tr;
    @(posedge clock); #1;
    start = 1'b0; trext = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("underrun_cleared", underrun, 0);
    dp = 0; hs = 0; aborted = 0;
    for (int t = 0; t <= last_t; t++) begin
      repeat ($urandom_range(0, 2)) @(posedge clock);
      @(negedge clock);
      in_valid = (ur >= 0) ? (dp < ur) : (dp < nbits);
      in_data  = in_valid ? bits[dp] : 1'b0;
      in_last  = in_valid && (ur < 0) && (dp == nbits - 1);
      if (t == restart_at) begin start = 1'b1; trext = ~tr; end
      clk_div = ~clk_div;
      #1;
      chk("in_ready", in_ready, exp_rdy[t]);
      if (in_ready && in_valid) begin hs++; dp++; end
      @(posedge clock); #1;
      start = 1'b0; trext = 1'b0;
      chk("bs_out", bs_out, exp_lvl[t]);
      chk("done", done, (t == last_t));
      chk("busy", busy, (t != last_t));
      if (t == stall_at) begin
        held = bs_out;
        repeat (100) @(posedge clock);
        #1;
        chk("stall_bs_out", bs_out, held);
        chk("stall_busy", busy, 1);
        chk("stall_done", done, 0);
      end
      if (t == abort_at) begin
        reset = 1'b0; clk_div = 1'b1;
        #1;
        chk("abort_bs_out", bs_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_underrun", underrun, 0);
        chk("abort_in_ready", in_ready, 0);
        repeat (3) begin
          @(posedge clock); #1;
          chk("abort_no_done", done, 0);
        end
        reset = 1'b1;
        aborted = 1;
        break;
      end
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = 1'b0;
    if (!aborted) begin
      @(posedge clock); #1;
      chk("done_single_cycle", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_bs_out", bs_out, 0);
      chk("underrun_flag", underrun, (ur >= 0));
      chk("handshakes", hs, (ur >= 0) ? ur : nbits);
    end
  endtask

  initial begin
    reset = 1'b0; clk_div = 1'b1; start = 1'b0; trext = 1'b0;
    in_valid = 1'b0; in_data = 1'b0; in_last = 1'b0;
    #12;
    chk("reset_bs_out", bs_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_underrun", underrun, 0);
    chk("reset_in_ready", in_ready, 0);
    @(negedge clock);
    reset = 1'b1;

    // Basic frame: bits 1,0,1, no pilot.
    bits.delete(); bits.push_back(1'b1); bits.push_back(1'b0); bits.push_back(1'b1);
    run_frame(1'b0, 3, -1, -1, -1, -1);

    // Pilot tone ahead of the preamble.
    fill_random(5);
    run_frame(1'b1, 5, -1, -1, -1, -1);

    // Upstream runs dry at the second data boundary.
    fill_random(4);
    run_frame(1'b0, 4, 1, -1, -1, -1);

    // Start pulses while busy, in preamble and in data.
    fill_random(4);
    run_frame(1'b0, 4, -1, -1, 3, -1);
    fill_random(4);
    run_frame(1'b1, 4, -1, -1, 40, -1);

    // Reset in the middle of DATA, then a clean frame.
    fill_random(6);
    run_frame(1'b0, 6, -1, -1, -1, 15);
    fill_random(3);
    run_frame(1'b1, 3, -1, -1, -1, -1);

    // Divider stopped mid-preamble.
    fill_random(4);
    run_frame(1'b0, 4, -1, 5, -1, -1);

    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(1, 8);
      fill_random(n);
      run_frame(1'($urandom_range(0, 1)), n, -1, -1, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fm0_encoder.md
FM0_ENCODER -- requirements
Module: fm0_encoder

Interface
REQ-001 SHALL have parameter PILOT_LEN, default 12, the number of FM0 data-0 pilot symbols sent when TRext is requested.
REQ-002 SHALL have parameter PREAMBLE, default 12'b110100100011, the FM0 preamble half-symbol levels, MSB first.
REQ-003 SHALL have port clock, input, 1, system clock; the only clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port clk_div, input, 1, divided clock level from the clock divider, synchronous to clock; each toggle is one half-symbol tick.
REQ-006 SHALL have port start, input, 1, single-cycle request to begin a reply frame.
REQ-007 SHALL have port trext, input, 1, pilot tone select, sampled with start.
REQ-008 SHALL have port in_valid, input, 1, upstream data bit valid.
REQ-009 SHALL have port in_data, input, 1, data bit.
REQ-010 SHALL have port in_last, input, 1, marks the final data bit.
REQ-011 SHALL have port in_ready, output, 1, bit accepted when in_valid && in_ready.
REQ-012 SHALL have port bs_out, output, 1, backscatter modulator level.
REQ-013 SHALL have port busy, output, 1, high from start acceptance until done.
REQ-014 SHALL have port done, output, 1, single-cycle end-of-frame pulse.
REQ-015 SHALL have port underrun, output, 1, sticky flag set when in_valid is low at a data symbol start; cleared by the next accepted start.

Function
REQ-016 SHALL register clk_div once into clk_div_q; tick = clk_div XOR clk_div_q; all state and bs_out updates occur only on cycles where tick = 1, except start acceptance and done.
REQ-017 SHALL implement states IDLE, PILOT, PREAMBLE, DATA, DUMMY, FINISH.
REQ-018 SHALL, in IDLE, accept start: latch trext, clear underrun, set busy, and move to PILOT if trext = 1, otherwise to PREAMBLE; start outside IDLE SHALL be ignored.
REQ-019 SHALL, in PILOT, emit PILOT_LEN data-0 symbols (2 ticks each; invert at both the symbol boundary and mid-symbol), then move to PREAMBLE.
REQ-020 SHALL, in PREAMBLE, drive bs_out from PREAMBLE bits, one bit per tick, MSB first (12 ticks), then move to DATA.
REQ-021 SHALL, in DATA, assert in_ready combinationally only on the boundary tick of each symbol; the bit is consumed on that cycle.
REQ-022 SHALL invert bs_out at every symbol boundary, and invert again at mid-symbol only for data 0.
REQ-023 SHALL move to DUMMY after the symbol whose bit carried in_last = 1 completes.
REQ-024 SHALL, if in_valid = 0 at a DATA boundary tick, set underrun, consume nothing, and move directly to DUMMY.
REQ-025 SHALL, in DUMMY, emit one data-1 symbol, then move to FINISH.
REQ-026 SHALL, in FINISH, on the next tick drive bs_out = 0, pulse done for exactly one clock cycle, deassert busy, and return to IDLE.
REQ-027 SHALL use a symbol/bit counter wide enough for max(PILOT_LEN, 12) x 2 half-symbols; no wrap-around within a phase.
REQ-028 SHALL hold all state when clk_div is static; a stopped divider freezes the frame without error.

Reset
REQ-029 SHALL, on reset low, asynchronously force state IDLE, counters 0, clk_div_q 1 (matches the divider reset level), bs_out 0, in_ready 0, busy 0, done 0, and underrun 0.
REQ-030 SHALL treat reset mid-frame as an abort: no done pulse; the frame is lost.

Structure
REQ-031 SHALL place the state enumeration, default PREAMBLE pattern and default PILOT_LEN in shared package fm0_pkg.
REQ-032 SHALL isolate clk_div sampling and tick generation in sub-module half_tick_gen.

Verification
REQ-033 SHALL test trext = 0, bits 1,0,1 with last on the third bit: exactly 12 preamble ticks plus 6 data ticks plus 2 dummy ticks, then done after 1 tick; bs_out returns to 0; 3 in_ready handshakes.
REQ-034 SHALL test trext = 1: 24 pilot ticks with bs_out toggling every tick precede the preamble.
REQ-035 SHALL test in_valid = 0 at the second data boundary: underrun = 1, DUMMY follows immediately, done pulses, and only 1 bit is consumed.
REQ-036 SHALL test start asserted while busy: ignored, and the frame length is unchanged.
REQ-037 SHALL test reset asserted mid-DATA: all outputs 0 in the same cycle, no done pulse, and the next start produces a correct frame.
REQ-038 SHALL test clk_div held static for 100 cycles mid-preamble: bs_out and state frozen, and the frame resumes correctly.
